// File: rtl/cpu_pkg.sv
// ============================================================================
// Module  : cpu_pkg
// Purpose : Shared opcode constants and sequencer state encoding.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t c_OP_NOP   = 5'b00000;
    localparam opcode_t c_OP_CALL  = 5'b11000;
    localparam opcode_t c_OP_CALL2 = 5'b11001;
    localparam opcode_t c_OP_RET   = 5'b11010;
    localparam opcode_t c_OP_RET2  = 5'b11011;
    localparam opcode_t c_OP_RTI   = 5'b11100;
    localparam opcode_t c_OP_RTI2  = 5'b11101;
    localparam opcode_t c_OP_INT1  = 5'b11110;
    localparam opcode_t c_OP_INT2  = 5'b11111;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CALL2 = 3'd1;
    localparam logic [2:0] c_ST_RET2  = 3'd2;
    localparam logic [2:0] c_ST_RTI2  = 3'd3;
    localparam logic [2:0] c_ST_INT1  = 3'd4;
    localparam logic [2:0] c_ST_INT2  = 3'd5;
    localparam logic [2:0] c_ST_FLUSH = 3'd6;

    // Second halves of multi-cycle ops may only be generated internally.
    function automatic logic isInternalOp(input opcode_t op);
        return (op == c_OP_CALL2) || (op == c_OP_RET2) || (op == c_OP_RTI2) ||
               (op == c_OP_INT1)  || (op == c_OP_INT2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/op_sequencer.sv
// ============================================================================
// Module  : op_sequencer
// Purpose : Expands CALL/RET/RTI into two-part issues, flushes after returns,
//           and injects interrupt sequences (macro OP_SEQUENCER_INT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module op_sequencer
    import cpu_pkg::*;
#(
    parameter int FLUSH_BUBBLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] op_in,
    input  logic       op_valid,
    input  logic       stall,
    input  logic       int_req,
    output logic [4:0] issue_op,
    output logic       bubble,
    output logic       pc_hold,
    output logic       int_ack,
    output logic       illegal
);

    localparam logic [1:0] c_FLUSH_LOAD = (FLUSH_BUBBLES > 0) ? 2'(FLUSH_BUBBLES - 1) : 2'd0;

    logic [2:0] r_state;
    logic [1:0] r_flushCnt;
    logic [2:0] w_nextState;
    logic [1:0] w_nextCnt;
    opcode_t    w_issueOp;
    logic       w_bubble;
    logic       w_pcHold;
    logic       w_intAck;
    logic       w_illegal;

`ifdef OP_SEQUENCER_INT_EN
    logic r_intPending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_intPending <= 1'b0;
        end else begin
            // A request landing on the acknowledge edge re-arms immediately.
            r_intPending <= int_req | (r_intPending & ~w_intAck);
        end
    end
`else
    logic w_unusedIntReq;
    assign w_unusedIntReq = int_req;
`endif

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_flushCnt;
        w_issueOp   = c_OP_NOP;
        w_bubble    = 1'b0;
        w_pcHold    = 1'b0;
        w_intAck    = 1'b0;
        w_illegal   = 1'b0;
        if (stall) begin
            w_bubble = 1'b1;
            w_pcHold = 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
`ifdef OP_SEQUENCER_INT_EN
                    if (r_intPending) begin
                        w_intAck    = 1'b1;
                        w_issueOp   = c_OP_INT1;
                        w_pcHold    = 1'b1;
                        w_nextState = c_ST_INT2;
                    end else
`endif
                    if (op_valid) begin
                        if (isInternalOp(op_in)) begin
                            w_illegal = 1'b1;
                        end else begin
                            w_issueOp = op_in;
                            case (op_in)
                                c_OP_CALL: begin
                                    w_pcHold    = 1'b1;
                                    w_nextState = c_ST_CALL2;
                                end
                                c_OP_RET: begin
                                    w_pcHold    = 1'b1;
                                    w_nextState = c_ST_RET2;
                                end
                                c_OP_RTI: begin
                                    w_pcHold    = 1'b1;
                                    w_nextState = c_ST_RTI2;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                c_ST_CALL2: begin
                    w_issueOp   = c_OP_CALL2;
                    w_nextState = c_ST_IDLE;
                end
                c_ST_RET2, c_ST_RTI2: begin
                    w_issueOp = (r_state == c_ST_RET2) ? c_OP_RET2 : c_OP_RTI2;
                    w_pcHold  = 1'b1;
                    w_nextCnt = c_FLUSH_LOAD;
                    if (FLUSH_BUBBLES == 0) begin
                        w_nextState = c_ST_IDLE;
                    end else begin
                        w_nextState = c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    w_bubble = 1'b1;
                    if (r_flushCnt == 2'd0) begin
                        w_nextState = c_ST_IDLE;
                    end else begin
                        w_nextCnt = r_flushCnt - 2'd1;
                    end
                end
`ifdef OP_SEQUENCER_INT_EN
                c_ST_INT1, c_ST_INT2: begin
                    w_issueOp   = c_OP_INT2;
                    w_pcHold    = 1'b1;
                    w_nextState = c_ST_IDLE;
                end
`endif
                default: w_nextState = c_ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_flushCnt <= 2'd0;
        end else begin
            r_state    <= w_nextState;
            r_flushCnt <= w_nextCnt;
        end
    end

    // Outputs are forced quiet while reset is held, independent of inputs.
    assign issue_op = rst_n ? w_issueOp : c_OP_NOP;
    assign bubble   = rst_n & w_bubble;
    assign pc_hold  = rst_n & w_pcHold;
    assign int_ack  = rst_n & w_intAck;
    assign illegal  = rst_n & w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_op_sequencer.sv
// Testbench for op_sequencer: queue-based reference model with a per-cycle
// compare process, plus directed sequences with literal expectations.
`default_nettype none

module tb_op_sequencer;

    localparam int FLUSH_BUBBLES = 2;
`ifdef OP_SEQUENCER_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] op_in;
    logic       op_valid;
    logic       stall;
    logic       int_req;
    logic [4:0] issue_op;
    logic       bubble;
    logic       pc_hold;
    logic       int_ack;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    op_sequencer #(.FLUSH_BUBBLES(FLUSH_BUBBLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_in    (op_in),
        .op_valid (op_valid),
        .stall    (stall),
        .int_req  (int_req),
        .issue_op (issue_op),
        .bubble   (bubble),
        .pc_hold  (pc_hold),
        .int_ack  (int_ack),
        .illegal  (illegal)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] op;
        logic       bub;
        logic       hold;
        logic       ack;
        logic       ill;
    } exp_t;

    // Model: a queue of still-owed issue slots plus the pending-interrupt bit.
    exp_t plan[$];
    bit   pending = 1'b0;

    function automatic exp_t mk(input logic [4:0] op, input logic bub, input logic hold);
        exp_t e;
        e = '0;
        e.op = op; e.bub = bub; e.hold = hold;
        return e;
    endfunction

    // kind: 0 plain, 1 interrupt, 2 call, 3 ret, 4 rti
    function automatic void predict(output exp_t e, output int kind);
        e = '0;
        kind = 0;
        if (!rst_n) return;
        if (stall) begin
            e.bub = 1'b1; e.hold = 1'b1;
            return;
        end
        if (plan.size() > 0) begin
            e = plan[0];
            return;
        end
        if (INT_EN && pending) begin
            e.op = 5'b11110; e.hold = 1'b1; e.ack = 1'b1; kind = 1;
            return;
        end
        if (!op_valid) return;
        case (op_in)
            5'b11001, 5'b11011, 5'b11101, 5'b11110, 5'b11111: e.ill = 1'b1;
            5'b11000: begin e.op = op_in; e.hold = 1'b1; kind = 2; end
            5'b11010: begin e.op = op_in; e.hold = 1'b1; kind = 3; end
            5'b11100: begin e.op = op_in; e.hold = 1'b1; kind = 4; end
            default:  e.op = op_in;
        endcase
    endfunction

    always @(posedge clk) begin : p_model
        exp_t e;
        int   k;
        predict(e, k);
        if (!rst_n) begin
            plan.delete();
            pending = 1'b0;
        end else begin
            if (!stall) begin
                if (plan.size() > 0) begin
                    void'(plan.pop_front());
                end else begin
                    case (k)
                        1: plan.push_back(mk(5'b11111, 1'b0, 1'b1));
                        2: plan.push_back(mk(5'b11001, 1'b0, 1'b0));
                        3, 4: begin
                            plan.push_back(mk((k == 3) ? 5'b11011 : 5'b11101, 1'b0, 1'b1));
                            for (int i = 0; i < FLUSH_BUBBLES; i++)
                                plan.push_back(mk(5'b00000, 1'b1, 1'b0));
                        end
                        default: ;
                    endcase
                end
            end
            pending = INT_EN && (int_req || (pending && !e.ack));
        end
    end

    int cycle = 0;
    always @(negedge clk) begin : p_compare
        exp_t e;
        int   k;
        exp_t act;
        predict(e, k);
        act = {issue_op, bubble, pc_hold, int_ack, illegal};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL model cycle %0d: got op=%b bub=%b hold=%b ack=%b ill=%b, expected op=%b bub=%b hold=%b ack=%b ill=%b",
                     cycle, act.op, act.bub, act.hold, act.ack, act.ill,
                     e.op, e.bub, e.hold, e.ack, e.ill);
        end
        cycle++;
    end

    task automatic lit(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [4:0] o, input logic s, input logic i);
        @(posedge clk);
        #1;
        op_valid = v; op_in = o; stall = s; int_req = i;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b1; op_in = 5'b01001; stall = 1'b0; int_req = 1'b0;
        @(negedge clk);
        #1;
        lit("reset issue_op", issue_op, 5'b00000);
        lit("reset bubble",   {4'b0, bubble},  5'd0);
        lit("reset pc_hold",  {4'b0, pc_hold}, 5'd0);
        lit("reset int_ack",  {4'b0, int_ack}, 5'd0);
        lit("reset illegal",  {4'b0, illegal}, 5'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; op_valid = 1'b0;

        cyc(1, 5'b01001, 0, 0);
        lit("plain issue", issue_op, 5'b01001);
        lit("plain bubble", {4'b0, bubble}, 5'd0);
        lit("plain hold", {4'b0, pc_hold}, 5'd0);

        cyc(1, 5'b11000, 0, 0);
        lit("call1 issue", issue_op, 5'b11000);
        lit("call1 hold", {4'b0, pc_hold}, 5'd1);
        cyc(0, 5'b00000, 0, 0);
        lit("call2 issue", issue_op, 5'b11001);
        lit("call2 hold", {4'b0, pc_hold}, 5'd0);
        cyc(0, 5'b00000, 0, 0);
        lit("call idle", issue_op, 5'b00000);

        cyc(1, 5'b11010, 0, 0);
        lit("ret1 issue", issue_op, 5'b11010);
        cyc(0, 5'b00000, 0, 0);
        lit("ret2 issue", issue_op, 5'b11011);
        lit("ret2 hold", {4'b0, pc_hold}, 5'd1);
        cyc(0, 5'b00000, 0, 0);
        lit("ret flush1", {4'b0, bubble}, 5'd1);
        cyc(0, 5'b00000, 0, 0);
        lit("ret flush2", {4'b0, bubble}, 5'd1);
        cyc(1, 5'b00011, 0, 0);
        lit("ret after", issue_op, 5'b00011);
        lit("ret after bubble", {4'b0, bubble}, 5'd0);

        cyc(1, 5'b11100, 0, 0);
        lit("rti1 issue", issue_op, 5'b11100);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 5'b00000, 1, 0);
            lit("rti2 stall bubble", {4'b0, bubble}, 5'd1);
            lit("rti2 stall hold", {4'b0, pc_hold}, 5'd1);
        end
        cyc(0, 5'b00000, 0, 0);
        lit("rti2 after stall", issue_op, 5'b11101);
        cyc(0, 5'b00000, 0, 0);
        cyc(0, 5'b00000, 0, 0);
        cyc(0, 5'b00000, 0, 0);
        lit("rti idle bubble", {4'b0, bubble}, 5'd0);

        cyc(1, 5'b11111, 0, 0);
        lit("illegal issue", issue_op, 5'b00000);
        lit("illegal pulse", {4'b0, illegal}, 5'd1);
        cyc(0, 5'b00000, 0, 0);
        lit("illegal cleared", {4'b0, illegal}, 5'd0);

`ifdef OP_SEQUENCER_INT_EN
        cyc(1, 5'b11000, 0, 0);
        cyc(1, 5'b00101, 0, 1);
        lit("int call2 issue", issue_op, 5'b11001);
        lit("int call2 ack", {4'b0, int_ack}, 5'd0);
        cyc(1, 5'b00101, 0, 0);
        lit("int1 ack", {4'b0, int_ack}, 5'd1);
        lit("int1 issue", issue_op, 5'b11110);
        cyc(1, 5'b00101, 0, 0);
        lit("int2 issue", issue_op, 5'b11111);
        lit("int2 hold", {4'b0, pc_hold}, 5'd1);
        cyc(1, 5'b00101, 0, 0);
        lit("int reissue", issue_op, 5'b00101);
`endif

        cyc(1, 5'b11000, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0; op_valid = 1'b1; op_in = 5'b00111;
        @(negedge clk);
        #1;
        lit("midreset issue", issue_op, 5'b00000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        lit("post reset idle", issue_op, 5'b00111);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            rst_n    = ($urandom_range(0, 199) != 0);
            op_valid = ($urandom_range(0, 3) != 0);
            op_in    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(24, 31))
                                                   : 5'($urandom_range(0, 31));
            stall    = ($urandom_range(0, 4) == 0);
            int_req  = ($urandom_range(0, 9) == 0);
        end
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
